// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: Zicsr operation encodings,
// FSM states, counter CSR addresses and read-only address-space decode.
package csr_access_unit_pkg;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate form.
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;
    localparam int         F3_IMM_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // User counter addresses served from the local cycle counter.
    localparam logic [11:0] CSR_CYCLE  = 12'hC00;
    localparam logic [11:0] CSR_TIME   = 12'hC01;
    localparam logic [11:0] CSR_CYCLEH = 12'hC80;
    localparam logic [11:0] CSR_TIMEH  = 12'hC81;

    // addr[11:10] == 2'b11 marks the read-only CSR space.
    localparam logic [11:0] RO_SPACE_MASK = 12'hC00;

    localparam int CNT_W = 64;

    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr & RO_SPACE_MASK) == RO_SPACE_MASK;
    endfunction

    // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero source field.
    function automatic logic writes_csr(input logic [1:0] op, input logic [4:0] rs1_field);
        return (op == OP_RW) || (rs1_field != 5'd0);
    endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter, exposed as low and high words.
module csr_cycle_counter
    import csr_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    logic [CNT_W-1:0] count;

    // Increment every cycle out of reset; wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + 64'd1;
        end
    end

    assign lo = count[31:0];
    assign hi = count[63:32];

endmodule

// File: rtl/csr_access_unit.sv
// Sequencing front end for the CSR file: accepts one Zicsr instruction,
// reads the CSR through the registered read port, performs the
// read-modify-write and returns the old value.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rs1_field,
    input  logic [31:0] req_rs1_val,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    output logic [11:0] csr_rd_addr,
    input  logic [31:0] csr_rd_data,
    output logic        csr_wr_en,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_wr_data
);

    state_t      state, state_next;
    logic [1:0]  op;
    logic [4:0]  rs1_field;
    logic [31:0] operand;
    logic [31:0] cnt_lo, cnt_hi;
    logic [31:0] old_val, new_val;
    logic        wr_intent, illegal;

    csr_cycle_counter u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .lo    (cnt_lo),
        .hi    (cnt_hi)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus handshake and write-port outputs; the write port is idle outside EXEC.
    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        csr_wr_en   = 1'b0;
        csr_wr_addr = 12'd0;
        csr_wr_data = 32'd0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_READ;
            end
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: begin
                if (wr_intent && !illegal) begin
                    csr_wr_en   = 1'b1;
                    csr_wr_addr = csr_rd_addr;
                    csr_wr_data = new_val;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request operands: plain data captured on accept, meaningful only in READ/EXEC.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            op        <= req_funct3[1:0];
            rs1_field <= req_rs1_field;
            operand   <= req_funct3[F3_IMM_BIT] ? {27'd0, req_rs1_field} : req_rs1_val;
        end
    end

    // Old value source, read-modify-write result and legality for the EXEC cycle.
    always_comb begin
        old_val = csr_rd_data;
        new_val = operand;
        case (csr_rd_addr)
            CSR_CYCLE,  CSR_TIME:  old_val = cnt_lo;
            CSR_CYCLEH, CSR_TIMEH: old_val = cnt_hi;
            default:               old_val = csr_rd_data;
        endcase
        case (op)
            OP_RS:   new_val = old_val | operand;
            OP_RC:   new_val = old_val & ~operand;
            default: new_val = operand;
        endcase
        wr_intent = writes_csr(op, rs1_field);
        illegal   = (op == OP_NONE) || (wr_intent && is_read_only(csr_rd_addr));
    end

    // Read address issued on accept; response registered in EXEC and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rd_addr <= 12'd0;
            rsp_rdata   <= 32'd0;
            rsp_illegal <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                csr_rd_addr <= req_csr_addr;
            end
            if (state == ST_EXEC) begin
                rsp_rdata   <= illegal ? 32'd0 : old_val;
                rsp_illegal <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: vector table through a response/write
// scoreboard plus hand-written back-pressure, counter-wrap and reset sequences.
module tb_csr_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rs1_field;
    logic [31:0] req_rs1_val;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;

    csr_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_csr_addr  (req_csr_addr),
        .req_rs1_field (req_rs1_field),
        .req_rs1_val   (req_rs1_val),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_illegal   (rsp_illegal),
        .csr_rd_addr   (csr_rd_addr),
        .csr_rd_data   (csr_rd_data),
        .csr_wr_en     (csr_wr_en),
        .csr_wr_addr   (csr_wr_addr),
        .csr_wr_data   (csr_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1f;
        logic [31:0] rs1v;
        logic [31:0] file;
        int          cnt_sel;   // 0: file value, 1: counter low word, 2: counter high word
        logic [31:0] exp_rdata;
        logic        exp_ill;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
    } rsp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          n_rsp = 0;
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem [0:4095];
    logic [63:0] cyc;
    logic [63:0] cnt_offset = 64'd0;
    logic [63:0] force_val;
    vec_t        vecs [17];

    // CSR file model: registered read port.
    always @(posedge clk) csr_rd_data <= mem[csr_rd_addr];

    // Reference cycle count: edges seen since reset released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 64'd0;
        else        cyc <= cyc + 64'd1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Response scoreboard: pop on handshake.
    always @(negedge clk) begin
        rsp_t e;
        #1;
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected rdata=0x%08h required=no response", rsp_rdata);
            end else begin
                e = rsp_q.pop_front();
                check32("rsp_rdata", rsp_rdata, e.rdata);
                check1("rsp_illegal", rsp_illegal, e.ill);
            end
            n_rsp++;
        end
    end

    // Write scoreboard: each cycle with csr_wr_en must match an expected write.
    always @(negedge clk) begin
        wr_t w;
        #1;
        if (csr_wr_en) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected addr=0x%03h data=0x%08h required=no write", csr_wr_addr, csr_wr_data);
            end else begin
                w = wr_q.pop_front();
                check32("wr_addr", {20'd0, csr_wr_addr}, {20'd0, w.addr});
                check32("wr_data", csr_wr_data, w.data);
            end
        end
    end

    function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1f,
                                input logic [31:0] rs1v, input logic [31:0] file, input int cnt_sel,
                                input logic [31:0] exp_rdata, input logic exp_ill, input logic exp_we,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.f3 = f3; v.addr = addr; v.rs1f = rs1f; v.rs1v = rs1v; v.file = file; v.cnt_sel = cnt_sel;
        v.exp_rdata = exp_rdata; v.exp_ill = exp_ill; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check1({tag, "_req_ready"}, req_ready, 1'b1);
        check1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check32({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check1({tag, "_rsp_illegal"}, rsp_illegal, 1'b0);
        check32({tag, "_rd_addr"}, {20'd0, csr_rd_addr}, 32'd0);
        check1({tag, "_wr_en"}, csr_wr_en, 1'b0);
        check32({tag, "_wr_addr"}, {20'd0, csr_wr_addr}, 32'd0);
        check32({tag, "_wr_data"}, csr_wr_data, 32'd0);
    endtask

    task automatic do_req(input vec_t v, input string tag, input int stall);
        logic [63:0] cv;
        rsp_t        r;
        wr_t         w;
        int          base;
        int          k;
        mem[v.addr] = v.file;
        base = n_rsp;
        @(negedge clk);
        check1({tag, "_req_ready"}, req_ready, 1'b1);
        req_valid     = 1'b1;
        req_funct3    = v.f3;
        req_csr_addr  = v.addr;
        req_rs1_field = v.rs1f;
        req_rs1_val   = v.rs1v;
        if (stall > 0) rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check1({tag, "_read_req_ready"}, req_ready, 1'b0);
        check1({tag, "_read_rsp_valid"}, rsp_valid, 1'b0);
        check32({tag, "_rd_addr"}, {20'd0, csr_rd_addr}, {20'd0, v.addr});
        @(negedge clk);
        cv = cnt_offset + cyc;
        r.rdata = (v.cnt_sel == 1) ? cv[31:0] : (v.cnt_sel == 2) ? cv[63:32] : v.exp_rdata;
        r.ill = v.exp_ill;
        rsp_q.push_back(r);
        if (v.exp_we) begin
            w.addr = v.addr;
            w.data = v.exp_wdata;
            wr_q.push_back(w);
        end
        check1({tag, "_exec_wr_en"}, csr_wr_en, v.exp_we);
        check1({tag, "_exec_rsp_valid"}, rsp_valid, 1'b0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            req_valid    = 1'b1;
            req_csr_addr = 12'h7FF;
            check1({tag, "_stall_rsp_valid"}, rsp_valid, 1'b1);
            check1({tag, "_stall_req_ready"}, req_ready, 1'b0);
            check1({tag, "_stall_wr_en"}, csr_wr_en, 1'b0);
            check32({tag, "_stall_rdata"}, rsp_rdata, r.rdata);
            check1({tag, "_stall_illegal"}, rsp_illegal, r.ill);
            check32({tag, "_stall_rd_addr"}, {20'd0, csr_rd_addr}, {20'd0, v.addr});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        k = 0;
        while (n_rsp == base && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (n_rsp == base) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout responses=%0d required=%0d", tag, n_rsp, base + 1);
        end
    endtask

    // Static so the force expression refers to a module-level variable.
    task force_counter(input logic [63:0] v);
        @(negedge clk);
        force_val = v;
        force dut.u_counter.count = force_val;
        cnt_offset = force_val - cyc;
        #1;
        release dut.u_counter.count;
    endtask

    initial begin
        int base;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_funct3    = 3'd0;
        req_csr_addr  = 12'd0;
        req_rs1_field = 5'd0;
        req_rs1_val   = 32'd0;
        rsp_ready     = 1'b1;

        vecs[0]  = mk(3'b001, 12'h340, 5'd5,  32'hA5A5_0000, 32'h0000_1234, 0, 32'h0000_1234, 1'b0, 1'b1, 32'hA5A5_0000);
        vecs[1]  = mk(3'b010, 12'h300, 5'd0,  32'hFFFF_FFFF, 32'h0000_0008, 0, 32'h0000_0008, 1'b0, 1'b0, 32'd0);
        vecs[2]  = mk(3'b111, 12'h341, 5'd3,  32'hFFFF_FFFF, 32'h0000_000F, 0, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_000C);
        vecs[3]  = mk(3'b010, 12'h305, 5'd7,  32'h0000_00F0, 32'h0000_000F, 0, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_00FF);
        vecs[4]  = mk(3'b011, 12'h305, 5'd2,  32'h0000_0005, 32'h0000_00FF, 0, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00FA);
        vecs[5]  = mk(3'b101, 12'h340, 5'd0,  32'hDEAD_BEEF, 32'h0000_0077, 0, 32'h0000_0077, 1'b0, 1'b1, 32'd0);
        vecs[6]  = mk(3'b110, 12'h300, 5'd16, 32'd0,         32'h0000_0001, 0, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0011);
        vecs[7]  = mk(3'b000, 12'h340, 5'd1,  32'h1234_5678, 32'h0000_0055, 0, 32'd0,         1'b1, 1'b0, 32'd0);
        vecs[8]  = mk(3'b100, 12'h340, 5'd1,  32'h1234_5678, 32'h0000_0055, 0, 32'd0,         1'b1, 1'b0, 32'd0);
        vecs[9]  = mk(3'b001, 12'hC00, 5'd1,  32'h0000_0001, 32'h5A5A_5A5A, 0, 32'd0,         1'b1, 1'b0, 32'd0);
        vecs[10] = mk(3'b010, 12'hF11, 5'd0,  32'hFFFF_FFFF, 32'h0000_ABCD, 0, 32'h0000_ABCD, 1'b0, 1'b0, 32'd0);
        vecs[11] = mk(3'b010, 12'hF11, 5'd1,  32'hFFFF_FFFF, 32'h0000_ABCD, 0, 32'd0,         1'b1, 1'b0, 32'd0);
        vecs[12] = mk(3'b010, 12'hC00, 5'd0,  32'd0,         32'h5A5A_5A5A, 1, 32'd0,         1'b0, 1'b0, 32'd0);
        vecs[13] = mk(3'b110, 12'hC80, 5'd0,  32'd0,         32'h5A5A_5A5A, 2, 32'd0,         1'b0, 1'b0, 32'd0);
        vecs[14] = mk(3'b011, 12'hC01, 5'd0,  32'hFFFF_FFFF, 32'h5A5A_5A5A, 1, 32'd0,         1'b0, 1'b0, 32'd0);
        vecs[15] = mk(3'b111, 12'hC81, 5'd0,  32'd0,         32'h5A5A_5A5A, 2, 32'd0,         1'b0, 1'b0, 32'd0);
        vecs[16] = mk(3'b101, 12'hB00, 5'd9,  32'd0,         32'h0000_0005, 0, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0009);

        // Reset state, both while held and just after release.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_released");

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i], $sformatf("v%0d", i), 0);
        end

        // Illegal funct3 held in RESP by back-pressure.
        do_req(mk(3'b100, 12'h340, 5'd3, 32'h0000_00FF, 32'h0000_0099, 0, 32'd0, 1'b1, 1'b0, 32'd0), "stall", 5);
        do_req(vecs[3], "after_stall", 0);

        // Low-word carry into the high word.
        force_counter(64'h0000_0000_FFFF_FFFD);
        do_req(vecs[12], "lo_carry", 0);
        do_req(vecs[13], "hi_carry", 0);
        // Full 64-bit wrap.
        force_counter(64'hFFFF_FFFF_FFFF_FFFD);
        do_req(vecs[15], "hi_wrap", 0);
        do_req(vecs[14], "lo_wrap", 0);

        // Reset asserted at the start of EXEC: write and response must vanish.
        mem[12'h340] = 32'h0000_1111;
        base = n_rsp;
        @(negedge clk);
        req_valid     = 1'b1;
        req_funct3    = 3'b001;
        req_csr_addr  = 12'h340;
        req_rs1_field = 5'd1;
        req_rs1_val   = 32'h0000_2222;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cnt_offset = 64'd0;
        @(negedge clk);
        check_idle_outputs("rst_exec");
        #3;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check32("rst_exec_no_rsp", n_rsp, base);
        check1("rst_exec_idle", req_ready, 1'b1);
        do_req(vecs[0], "post_reset", 0);
        do_req(vecs[12], "post_reset_cnt", 0);

        repeat (2) @(negedge clk);
        check32("rsp_q_drained", rsp_q.size(), 32'd0);
        check32("wr_q_drained", wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish before limit", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencing front end for the control and status register file. Accepts one decoded Zicsr instruction at a time from the execute stage, reads the addressed CSR through the file's registered read port, computes the read-modify-write result, issues the single write, and returns the old value for rd. Also owns the free-running 64-bit cycle counter, served read-only at the user counter addresses.

## Interface
- No parameters; CSR address width 12, data width 32, fixed.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CSR instruction offered
- req_ready  out  1  unit can accept (high only in IDLE)
- req_funct3  in  3  Zicsr funct3
- req_csr_addr  in  12  CSR address
- req_rs1_field  in  5  rs1 index (reg forms) or uimm (imm forms)
- req_rs1_val  in  32  rs1 register value (ignored for imm forms)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_rdata  out  32  old CSR value for rd
- rsp_illegal  out  1  illegal-instruction flag
- csr_rd_addr  out  12  to file read address
- csr_rd_data  in  32  from file, valid one cycle after address sampled
- csr_wr_en  out  1  file write strobe
- csr_wr_addr  out  12  file write address
- csr_wr_data  out  32  file write data

## Operation
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE: req_ready=1. On req_valid: latch funct3, address, rs1_field, operand (imm forms: zero-extended rs1_field, reg forms: rs1_val); csr_rd_addr <= address; go READ.
- READ: file samples csr_rd_addr at end of this cycle; go EXEC.
- EXEC: old = counter value if address is 0xC00/0xC01 (low word) or 0xC80/0xC81 (high word), else csr_rd_data. new: RW -> operand; RS -> old | operand; RC -> old & ~operand. Compute write-enable, assert csr_wr_en for exactly this cycle if enabled and legal; register rsp_rdata/rsp_illegal; go RESP.
- Write-enable: funct3 001/101 always write; 010/011/110/111 write only if rs1_field != 0.
- Illegal when: funct3 000 or 100; or write enabled and address[11:10]==2'b11 (read-only space, includes counters). Illegal -> no write, rsp_rdata=0, rsp_illegal=1.
- RESP: rsp_valid=1, rsp_rdata/rsp_illegal held stable until rsp_valid&&rsp_ready, then IDLE.
- Cycle counter: 64 bits, increments every cycle out of reset, wraps 2^64-1 -> 0; never written by this unit.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, csr_rd_addr=0, csr_wr_en=0, csr_wr_addr=0, csr_wr_data=0, counter=0.
- Accept edge T0; READ T1; EXEC T2 (csr_wr_en high); RESP from T3. Best-case request-to-request spacing 4 cycles.
- csr_wr_en, csr_wr_addr, csr_wr_data driven combinationally in EXEC from registered state; zero outside EXEC.
- Counter value used is the value in the EXEC cycle; high and low words read by separate instructions, no atomicity.
- Back-pressure in RESP: unit stalls indefinitely, outputs constant, no further file traffic.
- Reset asserted in any state: immediate return to IDLE, pending write never issued, response discarded.
- req_valid in non-IDLE states ignored (req_ready=0).

## Structure
- Shared defines include (alongside the rv32i defines): Zicsr funct3 encodings, FSM state encodings, counter CSR addresses, read-only address-space mask.
- One sub-module: csr_cycle_counter (64-bit free-running counter, async active-low reset, lo/hi outputs).

## Test plan
- CSRRW 0x340 with file holding 0x1234, rs1_val 0xA5A5_0000 -> wr_en one cycle in T2 with data 0xA5A5_0000, rsp_rdata 0x1234 at T3, illegal 0.
- CSRRS 0x300 rs1_field=0, old 0x8 -> no wr_en, rsp_rdata 0x8; CSRRCI uimm 0x3, old 0xF -> write 0xC.
- CSRRS 0xC00 rs1_field=0 at known cycle count N -> rsp_rdata = low word of counter at EXEC; CSRRW 0xC00 -> rsp_illegal=1, rdata 0, no wr_en.
- funct3=100 -> rsp_illegal=1, no write; rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready 0 throughout.
- Counter preloaded via force to 0x0000_0000_FFFF_FFFF -> next cycle reads low 0, high 1; full 64-bit wrap to 0.
- rst_n pulsed low during EXEC -> no csr_wr_en edge sampled, all outputs at reset values, next request completes normally.
